salida_uart_tx: RTL and testbench

Output stage downstream of the single-cycle CPU's 16-bit `salida` port. It watches `salida` for value changes and queues each new value in a small FIFO. Queued words are serialized over a UART TX line, high byte first, as 8N1 frames. This lets the CPU's output be logged on a host terminal without stalling the processor.

---
 rtl/salida_uart_tx_if.sv | 29 ++
 rtl/salida_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_salida_uart_tx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/salida_uart_tx_if.sv
// Bus bundle between the CPU `salida` output and the UART logging stage.
// The CPU side uses the master modport; the UART stage uses slave.
interface salida_uart_tx_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   salida;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  modport master (
    output salida,
    input  tx,
    input  busy,
    input  overflow,
    input  fifo_count
  );

  modport slave (
    input  salida,
    output tx,
    output busy,
    output overflow,
    output fifo_count
  );
endinterface

// File: rtl/salida_uart_tx.sv
// Queues every change of the CPU `salida` word and sends it as two UART frames,
// high byte first. Define SALIDA_PARITY_EN for 8E1 frames (default 8N1).
module salida_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic              clk,
  input logic              reset,
  salida_uart_tx_if.slave  bus
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   LAST_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SALIDA_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // change detect and FIFO
  logic [15:0]   prev_salida;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow_q;
  logic          push_req, push_ok, pop, full, empty;

  // transmitter
  state_t        state, state_d;
  logic [15:0]   clk_cnt, clk_cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic          byte_sel, byte_sel_d;
  logic [15:0]   word, word_d;
  logic [7:0]    cur_byte;
  logic          tick;
  logic          tx_c;

  always_comb begin
    push_req = (bus.salida != prev_salida);
    empty    = (count == '0);
    full     = (count == FULL_C);
    pop      = (state == S_IDLE) && !empty;
    // a pop on the same edge frees a slot, so a push into a full FIFO still lands
    push_ok  = push_req && (!full || pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_salida <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      prev_salida <= bus.salida;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.salida;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
      word     <= '0;
    end else begin
      state    <= state_d;
      clk_cnt  <= clk_cnt_d;
      bit_idx  <= bit_idx_d;
      byte_sel <= byte_sel_d;
      word     <= word_d;
    end
  end

  always_comb begin
    state_d    = state;
    clk_cnt_d  = clk_cnt + 16'd1;
    bit_idx_d  = bit_idx;
    byte_sel_d = byte_sel;
    word_d     = word;
    tx_c       = 1'b1;
    tick       = (clk_cnt == LAST_CNT);
    cur_byte   = byte_sel ? word[15:8] : word[7:0];

    case (state)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (pop) begin
          word_d     = mem[rd_ptr];
          byte_sel_d = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        tx_c = 1'b0;
        if (tick) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        tx_c = cur_byte[bit_idx];
        if (tick) begin
          clk_cnt_d = '0;
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef SALIDA_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef SALIDA_PARITY_EN
      S_PARITY: begin
        tx_c = ^cur_byte;
        if (tick) begin
          clk_cnt_d = '0;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        tx_c = 1'b1;
        if (tick) begin
          clk_cnt_d = '0;
          if (byte_sel) begin
            byte_sel_d = 1'b0;
            state_d    = S_START;
          end else begin
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.tx         = tx_c;
  assign bus.busy       = (state != S_IDLE) || !empty;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_salida_uart_tx.sv
// Randomized bench for salida_uart_tx: per-cycle comparison of tx/busy/count/overflow
// against a word-queue model that derives the serial waveform from frame arithmetic.
module tb_salida_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef SALIDA_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int FRAME    = NBITS * CPB;
  localparam int WORD_CYC = 2 * FRAME;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  salida_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  salida_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // model: queue of pending words plus position within the word on the wire
  logic [15:0] m_q[$];
  logic [15:0] m_prev = '0;
  logic [15:0] m_cur  = '0;
  logic [15:0] m_s;
  bit          m_active = 1'b0;
  int          m_t = 0;
  bit          m_ovf = 1'b0;
  bit          m_pop, m_full, m_push;

  function automatic logic exp_tx(input logic [15:0] w, input int t);
    int f, b;
    logic [7:0] by;
    f  = t / FRAME;
    b  = (t % FRAME) / CPB;
    by = (f == 0) ? w[15:8] : w[7:0];
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    if (PAR && b == 9) return ^by;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_prev   = '0;
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
    end else begin
      m_s    = bus.salida;
      m_full = (m_q.size() == DEPTH);
      m_pop  = !m_active && (m_q.size() != 0);
      m_push = (m_s != m_prev);
      if (m_active) begin
        m_t++;
        if (m_t == WORD_CYC) m_active = 1'b0;
      end
      if (m_pop) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (m_push) begin
        if (!m_full || m_pop) m_q.push_back(m_s);
        else                  m_ovf = 1'b1;
      end
      m_prev = m_s;
    end
  end

  always @(negedge clk) begin
    check_eq("tx",         bus.tx,         m_active ? exp_tx(m_cur, m_t) : 1'b1);
    check_eq("busy",       bus.busy,       m_active || (m_q.size() != 0));
    check_eq("fifo_count", bus.fifo_count, m_q.size());
    check_eq("overflow",   bus.overflow,   m_ovf);
  end

  task automatic set_salida(input logic [15:0] v);
    @(negedge clk);
    bus.salida = v;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((m_active || m_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_bound", n < limit, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.salida = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int gap, burst;
    bus.salida = '0;

    // reset held while the bus toggles
    repeat (8) begin
      @(negedge clk);
      bus.salida = 16'($urandom);
    end
    @(negedge clk);
    bus.salida = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("post_reset_busy", bus.busy, 1'b0);

    // single word, start bit two cycles after the change
    set_salida(16'hA53C);
    @(negedge clk);
    check_eq("pre_start_tx", bus.tx, 1'b1);
    @(negedge clk);
    check_eq("start_lat", bus.tx, 1'b0);
    drain(200);

    // burst of five consecutive changes, then a dropped sixth
    for (int v = 1; v <= 5; v++) set_salida(16'(v));
    @(negedge clk);
    check_eq("burst_count", bus.fifo_count, 4);
    check_eq("burst_ovf",   bus.overflow, 1'b0);
    repeat (10) @(negedge clk);
    set_salida(16'h0006);
    repeat (2) @(negedge clk);
    check_eq("drop_ovf", bus.overflow, 1'b1);
    drain(1000);

    // push on the exact pop edge while full
    do_reset();
    for (int v = 0; v < 5; v++) set_salida(16'(16'h0100 + v));
    n = 0;
    while (!(!m_active && m_q.size() == DEPTH) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("full_pop_wait", n < 500, 1'b1);
    bus.salida = 16'h01FF;
    @(negedge clk);
    check_eq("full_pop_count", bus.fifo_count, 4);
    check_eq("full_pop_ovf",   bus.overflow, 1'b0);
    drain(2000);

    // reset during data bit 3 of the high byte
    set_salida(16'hBEEF);
    n = 0;
    while (!(m_active && m_t == CPB * 4 + 1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("midframe_wait", n < 200, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_tx",    bus.tx, 1'b1);
    check_eq("rst_async_count", bus.fifo_count, 0);
    check_eq("rst_async_busy",  bus.busy, 1'b0);
    bus.salida = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    set_salida(16'h1234);
    drain(200);

`ifdef SALIDA_PARITY_EN
    set_salida(16'h00FF);
    drain(200);
    set_salida(16'h0001);
    drain(200);
`endif

    // random gaps and bursts
    repeat (150) begin
      gap = $urandom_range(0, 60);
      repeat (gap) @(negedge clk);
      burst = $urandom_range(1, 6);
      repeat (burst) set_salida(16'($urandom));
    end
    drain(5000);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", err_cnt);
    $fatal(1);
  end
endmodule
